regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-back arbiter and scoreboard for the 32x32 register file (2 read, 1 write port).
//  Shares the single write port among NREQ result producers (ALU, load unit, CSR, ...)
//  using round-robin arbitration with a valid/ready handshake.
//  Tracks in-flight destination registers and flags RAW hazards to the issue stage.
// PARAMETERS
//  NREQ    3   number of write-back requesters (2..8)
//  DATA_W  32  write data width
//  ADDR_W  5   register index width (32 registers; x0 hardwired zero)
// PORTS
//  clock        in   1             system clock; all state updates on posedge
//  reset_n      in   1             asynchronous, active-low reset
//  req_valid    in   NREQ          requester i has a result pending
//  req_rd       in   NREQ*ADDR_W   dest index; slice i = [i*ADDR_W +: ADDR_W]
//  req_data     in   NREQ*DATA_W   result;     slice i = [i*DATA_W +: DATA_W]
//  req_ready    out  NREQ          one-hot grant; handshake = valid & ready
//  issue_valid  in   1             issue stage dispatches an instr writing issue_rd
//  issue_rd     in   ADDR_W        destination of issuing instruction
//  rs1, rs2     in   ADDR_W        sources of instruction at issue
//  stall        out  1             RAW hazard on rs1 or rs2; issue must hold
//  RegWrite     out  1             to register file write enable (registered)
//  rd           out  ADDR_W        to register file write index (registered)
//  write_data   out  DATA_W        to register file write data (registered)
// BEHAVIOUR
//  Reset (async, reset_n=0): RegWrite=0, rd=0, write_data=0, busy[31:0]=0, rr_ptr=0;
//   req_ready=0 while reset asserted. Reset mid-transfer drops the registered write.
//  Arbitration (combinational): scan i = rr_ptr, rr_ptr+1, ... mod NREQ; first
//   req_valid[i] gets req_ready[i]=1; at most one bit of req_ready set; none if no valid.
//  On handshake of i: rr_ptr <= (i+1) mod NREQ; no handshake -> rr_ptr holds.
//  Requester holds valid, rd, data stable until ready; it may not withdraw valid.
//  Write latency: handshake at edge N -> RegWrite=1, rd, write_data valid after edge N,
//   register file commits at edge N+1. One write per cycle max; back-to-back grants
//   keep RegWrite high continuously.
//  rd=0 request: accepted (ready, pointer advances) but RegWrite stays 0 (discarded).
//  Scoreboard busy[31:0], busy[0] always 0:
//   set   busy[issue_rd] at edge when issue_valid && !stall && issue_rd!=0;
//   clear busy[rd] at edge when RegWrite=1 (same edge the register file commits);
//   set and clear of same index in same cycle -> set wins (newer producer pending).
//  stall = (rs1!=0 && busy[rs1]) || (rs2!=0 && busy[rs2]); purely combinational.
//   issue_valid while stall=1 is ignored by the scoreboard.
//  Arbiter never inspects busy; requesters own write ordering to the same rd.
// CONFIGURATION
//  WB_FWD_EN defined: adds ports fwd1_valid/fwd2_valid (out,1) and
//   fwd1_data/fwd2_data (out,DATA_W). fwdN_valid = RegWrite && rd==rsN && rsN!=0;
//   fwdN_data = write_data. Stall term for rsN becomes busy[rsN] && !fwdN_valid,
//   removing the 1-cycle bubble while the write is on the port.
//  WB_FWD_EN undefined: forwarding ports absent; stall as specified above.
// TESTING
//  1 reset: reset_n=0 with req_valid=3'b111 -> req_ready=0, RegWrite=0, stall=0; release
//    -> req_ready=3'b001 in first cycle.
//  2 round-robin: all three valid, held 6 cycles -> grants 0,1,2,0,1,2; RegWrite=1 each
//    cycle after first grant, rd/write_data follow granted slice one cycle later.
//  3 x0 discard: req0 rd=0 data=32'hDEAD_BEEF -> req_ready[0]=1, RegWrite stays 0,
//    rr_ptr=1.
//  4 hazard: issue rd=5, then rs1=5 -> stall=1 until req writes rd=5 data=32'h1234;
//    stall=0 cycle after RegWrite edge (WB_FWD_EN: stall=0 in RegWrite cycle,
//    fwd1_valid=1, fwd1_data=32'h1234).
//  5 set/clear collision: RegWrite rd=7 and issue_valid issue_rd=7 same cycle ->
//    busy[7]=1 afterward; rs2=7 gives stall=1.
//  6 async reset mid-write: assert reset_n=0 between edges with RegWrite=1 -> RegWrite=0
//    immediately, busy cleared, no register file write at next edge.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file, plus an in-flight destination scoreboard for RAW stalls.
// Optional macro WB_FWD_EN adds write-port forwarding outputs and removes the write-cycle stall bubble.
`timescale 1ns/1ps
module regfile_wb_arbiter #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*ADDR_W-1:0] req_rd,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   issue_valid,
   input  logic [ADDR_W-1:0]      issue_rd,
   input  logic [ADDR_W-1:0]      rs1,
   input  logic [ADDR_W-1:0]      rs2,
`ifdef WB_FWD_EN
   output logic                   fwd1_valid,
   output logic                   fwd2_valid,
   output logic [DATA_W-1:0]      fwd1_data,
   output logic [DATA_W-1:0]      fwd2_data,
`endif
   output logic                   stall,
   output logic                   RegWrite,
   output logic [ADDR_W-1:0]      rd,
   output logic [DATA_W-1:0]      write_data
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int NREGS = 1 << ADDR_W;

   logic [PTR_W-1:0]  r_rr_ptr;
   logic              r_regwrite;
   logic [ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0] r_wdata;
   logic [NREGS-1:0]  r_busy;

   logic [PTR_W-1:0]  w_idx_k;
   logic [PTR_W-1:0]  w_gnt_idx;
   logic [PTR_W-1:0]  w_ptr_nxt;
   logic              w_found;
   logic              w_hs;
   logic [NREQ-1:0]   w_grant;
   logic [ADDR_W-1:0] w_gnt_rd;
   logic [DATA_W-1:0] w_gnt_data;
   logic [NREGS-1:0]  w_busy_nxt;
   logic              w_hz1;
   logic              w_hz2;

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      return s[PTR_W-1:0];
   endfunction

   // Scan starting at the round-robin pointer; first valid requester wins.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_idx_k   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx_k = wrap_add(r_rr_ptr, k);
         if (!w_found && req_valid[w_idx_k]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_idx_k;
         end
      end
      w_hs    = w_found & reset_n;
      w_grant = '0;
      if (w_hs) w_grant[w_gnt_idx] = 1'b1;
   end

   assign req_ready  = w_grant;
   assign w_ptr_nxt  = wrap_add(w_gnt_idx, 1);
   assign w_gnt_rd   = req_rd[w_gnt_idx*ADDR_W +: ADDR_W];
   assign w_gnt_data = req_data[w_gnt_idx*DATA_W +: DATA_W];

   // Writes to x0 are accepted from the requester but never reach the register file.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_regwrite <= 1'b0;
         r_rd       <= '0;
         r_wdata    <= '0;
         r_rr_ptr   <= '0;
      end else begin
         r_regwrite <= w_hs && (w_gnt_rd != '0);
         if (w_hs) begin
            r_rd     <= w_gnt_rd;
            r_wdata  <= w_gnt_data;
            r_rr_ptr <= w_ptr_nxt;
         end
      end
   end

   assign RegWrite   = r_regwrite;
   assign rd         = r_rd;
   assign write_data = r_wdata;

   // Set is applied after clear so a newly issued producer of the same register stays pending.
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_regwrite) w_busy_nxt[r_rd] = 1'b0;
      if (issue_valid && !stall && (issue_rd != '0)) w_busy_nxt[issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_busy <= '0;
      else          r_busy <= w_busy_nxt;
   end

`ifdef WB_FWD_EN
   assign fwd1_valid = r_regwrite && (r_rd == rs1) && (rs1 != '0);
   assign fwd2_valid = r_regwrite && (r_rd == rs2) && (rs2 != '0);
   assign fwd1_data  = r_wdata;
   assign fwd2_data  = r_wdata;
   assign w_hz1      = (rs1 != '0) && r_busy[rs1] && !fwd1_valid;
   assign w_hz2      = (rs2 != '0) && r_busy[rs2] && !fwd2_valid;
`else
   assign w_hz1      = (rs1 != '0) && r_busy[rs1];
   assign w_hz2      = (rs2 != '0) && r_busy[rs2];
`endif

   assign stall = w_hz1 | w_hz2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected write-backs are queued at stimulus time
// and a negedge monitor pops and compares them whenever RegWrite is presented.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

   localparam int NREQ   = 3;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic                   clock = 1'b0;
   logic                   reset_n;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*ADDR_W-1:0] req_rd;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   issue_valid;
   logic [ADDR_W-1:0]      issue_rd;
   logic [ADDR_W-1:0]      rs1;
   logic [ADDR_W-1:0]      rs2;
   logic                   stall;
   logic                   RegWrite;
   logic [ADDR_W-1:0]      rd;
   logic [DATA_W-1:0]      write_data;
`ifdef WB_FWD_EN
   logic                   fwd1_valid;
   logic                   fwd2_valid;
   logic [DATA_W-1:0]      fwd1_data;
   logic [DATA_W-1:0]      fwd2_data;
`endif

   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_t;

   wb_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   logic [DATA_W-1:0] base_d [NREQ];

   always #5 clock = ~clock;

   regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_rd      (req_rd),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1         (rs1),
      .rs2         (rs2),
`ifdef WB_FWD_EN
      .fwd1_valid  (fwd1_valid),
      .fwd2_valid  (fwd2_valid),
      .fwd1_data   (fwd1_data),
      .fwd2_data   (fwd2_data),
`endif
      .stall       (stall),
      .RegWrite    (RegWrite),
      .rd          (rd),
      .write_data  (write_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
      req_rd[i*ADDR_W +: ADDR_W]   = r;
      req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
      wb_t e;
      e.rd   = r;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Monitor: every register-file write must match the oldest queued expectation.
   always @(negedge clock) begin
      if (reset_n && RegWrite) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got rd %0d data %0h, expected no write", rd, write_data);
         end else begin
            wb_t e;
            e = exp_q.pop_front();
            chk("wb_rd", 64'(rd), 64'(e.rd));
            chk("wb_data", 64'(write_data), 64'(e.data));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      base_d[0] = 32'hA000_0000;
      base_d[1] = 32'hA111_1111;
      base_d[2] = 32'hA222_2222;
      reset_n     = 1'b0;
      req_valid   = 3'b111;
      req_rd      = '0;
      req_data    = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      rs1         = '0;
      rs2         = '0;
      for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i + 1), base_d[i]);

      // Reset holds off all grants and writes.
      #12;
      chk("reset_ready", 64'(req_ready), 64'(0));
      chk("reset_regwrite", 64'(RegWrite), 64'(0));
      chk("reset_stall", 64'(stall), 64'(0));
      chk("reset_rd", 64'(rd), 64'(0));
      chk("reset_wdata", 64'(write_data), 64'(0));
      reset_n = 1'b1;
      #1;

      // Round-robin with all three requesters held valid.
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
         push(ADDR_W'((k % 3) + 1), base_d[k % 3]);
         next_cycle();
      end
      req_valid = '0;
      #1;
      chk("rr_idle_ready", 64'(req_ready), 64'(0));
      chk("rr_regwrite_last", 64'(RegWrite), 64'(1));
      next_cycle();

      // x0 destination is accepted and discarded, pointer still advances.
      set_req(0, '0, 32'hDEAD_BEEF);
      req_valid = 3'b001;
      #1;
      chk("x0_ready", 64'(req_ready), 64'(3'b001));
      next_cycle();
      chk("x0_regwrite", 64'(RegWrite), 64'(0));
      set_req(1, 5'd2, 32'h0000_B001);
      req_valid = 3'b011;
      #1;
      chk("x0_ptr_advanced", 64'(req_ready), 64'(3'b010));
      push(5'd2, 32'h0000_B001);
      next_cycle();
      chk("x0_second_ready", 64'(req_ready), 64'(3'b001));
      next_cycle();
      req_valid = '0;
      chk("x0_second_regwrite", 64'(RegWrite), 64'(0));

      // RAW hazard on rs1 until the write-back of x5.
      issue_valid = 1'b1;
      issue_rd    = 5'd5;
      next_cycle();
      issue_valid = 1'b0;
      rs1         = 5'd5;
      #1;
      chk("hazard_stall", 64'(stall), 64'(1));
      next_cycle();
      chk("hazard_hold", 64'(stall), 64'(1));
      set_req(2, 5'd5, 32'h0000_1234);
      req_valid = 3'b100;
      push(5'd5, 32'h0000_1234);
      #1;
      chk("hazard_wb_ready", 64'(req_ready), 64'(3'b100));
      next_cycle();
      req_valid = '0;
      #1;
`ifdef WB_FWD_EN
      chk("hazard_fwd_stall", 64'(stall), 64'(0));
      chk("hazard_fwd1_valid", 64'(fwd1_valid), 64'(1));
      chk("hazard_fwd1_data", 64'(fwd1_data), 64'(32'h0000_1234));
      chk("hazard_fwd2_valid", 64'(fwd2_valid), 64'(0));
`else
      chk("hazard_wb_cycle_stall", 64'(stall), 64'(1));
`endif
      next_cycle();
      chk("hazard_clear", 64'(stall), 64'(0));
      rs1 = '0;

      // Same-cycle clear and set of x7: set wins.
      set_req(0, 5'd7, 32'h0000_0077);
      req_valid = 3'b001;
      #1;
      chk("collide_ready", 64'(req_ready), 64'(3'b001));
      push(5'd7, 32'h0000_0077);
      next_cycle();
      req_valid   = '0;
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      #1;
      chk("collide_regwrite", 64'(RegWrite), 64'(1));
      next_cycle();
      issue_valid = 1'b0;
      rs2         = 5'd7;
      #1;
      chk("collide_set_wins", 64'(stall), 64'(1));

      // Asynchronous reset while a write is on the port.
      set_req(1, 5'd9, 32'h0000_0099);
      req_valid = 3'b010;
      #1;
      chk("areset_pre_ready", 64'(req_ready), 64'(3'b010));
      next_cycle();
      req_valid = '0;
      chk("areset_pre_regwrite", 64'(RegWrite), 64'(1));
      chk("areset_pre_rd", 64'(rd), 64'(9));
      #1;
      reset_n = 1'b0;
      #1;
      chk("areset_regwrite", 64'(RegWrite), 64'(0));
      chk("areset_rd", 64'(rd), 64'(0));
      chk("areset_wdata", 64'(write_data), 64'(0));
      chk("areset_busy_cleared", 64'(stall), 64'(0));
      next_cycle();
      reset_n = 1'b1;
      @(negedge clock);
      chk("areset_no_write", 64'(RegWrite), 64'(0));
      set_req(0, 5'd4, 32'h0000_0044);
      req_valid = 3'b011;
      #1;
      chk("areset_ptr_zero", 64'(req_ready), 64'(3'b001));
      push(5'd4, 32'h0000_0044);
      push(5'd9, 32'h0000_0099);
      next_cycle();
      chk("areset_next_ready", 64'(req_ready), 64'(3'b010));
      next_cycle();
      req_valid = '0;
      repeat (3) next_cycle();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
